// File: rtl/alu_issue_stage_pkg.sv
// alu_issue_stage_pkg
//   Shared definitions for the ALU issue stage:
//   - datapath widths (WORD_WIDTH, ALU_CTL_WIDTH, SHAMT_WIDTH)
//   - ALU control codes (ALU_*), the encoding the ALU consumes
//   - RV32I opcode and funct3 constants
//   - operand-select enums and the registered issue payload struct
package alu_issue_stage_pkg;

  localparam int WORD_WIDTH    = 32;
  localparam int ALU_CTL_WIDTH = 4;
  localparam int SHAMT_WIDTH   = 5;

  // ALU control codes
  localparam logic [ALU_CTL_WIDTH-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_CTL_WIDTH-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_CTL_WIDTH-1:0] ALU_SLL  = 4'd2;
  localparam logic [ALU_CTL_WIDTH-1:0] ALU_SLT  = 4'd3;
  localparam logic [ALU_CTL_WIDTH-1:0] ALU_SLTU = 4'd4;
  localparam logic [ALU_CTL_WIDTH-1:0] ALU_XOR  = 4'd5;
  localparam logic [ALU_CTL_WIDTH-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALU_CTL_WIDTH-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALU_CTL_WIDTH-1:0] ALU_OR   = 4'd8;
  localparam logic [ALU_CTL_WIDTH-1:0] ALU_AND  = 4'd9;
  localparam logic [ALU_CTL_WIDTH-1:0] ALU_SEQ  = 4'd10;
  localparam logic [ALU_CTL_WIDTH-1:0] ALU_SNE  = 4'd11;
  localparam logic [ALU_CTL_WIDTH-1:0] ALU_SGE  = 4'd12;
  localparam logic [ALU_CTL_WIDTH-1:0] ALU_SGEU = 4'd13;

  // RV32I major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  // OP / OP-IMM funct3
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // BRANCH funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    A_ZERO = 2'd0,
    A_RS1  = 2'd1,
    A_PC   = 2'd2
  } a_sel_e;

  typedef enum logic [2:0] {
    B_ZERO  = 3'd0,
    B_RS2   = 3'd1,
    B_IMM_I = 3'd2,
    B_IMM_S = 3'd3,
    B_IMM_U = 3'd4,
    B_SHAMT = 3'd5,
    B_FOUR  = 3'd6
  } b_sel_e;

  typedef struct packed {
    logic [WORD_WIDTH-1:0]    a;
    logic [WORD_WIDTH-1:0]    b;
    logic [ALU_CTL_WIDTH-1:0] ctl;
    logic [4:0]               rd;
    logic                     wb_en;
    logic                     is_branch;
    logic                     illegal;
    logic [WORD_WIDTH-1:0]    pc;
  } issue_t;

endpackage

// File: rtl/alu_issue_stage_ctl_decode.sv
// alu_ctl_decode
//   Combinational RV32I decode for the ALU issue stage.
//   Inputs : opcode, funct3, funct7 and rd fields of the instruction.
//   Outputs: ctl (ALU control code), a_sel / b_sel (operand selects),
//            wb_en, is_branch, illegal.
//   Any undecodable word is forced to the safe form: ctl=ADD, both
//   operands zero, no writeback, not a branch.
module alu_ctl_decode
  import alu_issue_stage_pkg::*;
(
  input  logic [6:0]               opcode,
  input  logic [2:0]               funct3,
  input  logic [6:0]               funct7,
  input  logic [4:0]               rd,
  output logic [ALU_CTL_WIDTH-1:0] ctl,
  output a_sel_e                   a_sel,
  output b_sel_e                   b_sel,
  output logic                     wb_en,
  output logic                     is_branch,
  output logic                     illegal
);

  logic rd_nz;
  logic alt;
  logic ctl_ill;

  assign rd_nz = (rd != 5'd0);
  assign alt   = funct7[5];

  always_comb begin
    ctl       = ALU_ADD;
    a_sel     = A_ZERO;
    b_sel     = B_ZERO;
    wb_en     = 1'b0;
    is_branch = 1'b0;
    ctl_ill   = 1'b0;

    unique case (opcode)
      OPC_OP: begin
        a_sel = A_RS1;
        b_sel = B_RS2;
        wb_en = rd_nz;
        // Only ADD/SUB and SRL/SRA have an alternate funct7 form.
        if (!((funct7 == F7_BASE) ||
              ((funct7 == F7_ALT) &&
               ((funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA))))) begin
          ctl_ill = 1'b1;
        end
        unique case (funct3)
          F3_ADD_SUB: ctl = alt ? ALU_SUB : ALU_ADD;
          F3_SLL:     ctl = ALU_SLL;
          F3_SLT:     ctl = ALU_SLT;
          F3_SLTU:    ctl = ALU_SLTU;
          F3_XOR:     ctl = ALU_XOR;
          F3_SRL_SRA: ctl = alt ? ALU_SRA : ALU_SRL;
          F3_OR:      ctl = ALU_OR;
          default:    ctl = ALU_AND;
        endcase
      end

      OPC_OP_IMM: begin
        a_sel = A_RS1;
        b_sel = B_IMM_I;
        wb_en = rd_nz;
        unique case (funct3)
          F3_ADD_SUB: ctl = ALU_ADD;
          F3_SLT:     ctl = ALU_SLT;
          F3_SLTU:    ctl = ALU_SLTU;
          F3_XOR:     ctl = ALU_XOR;
          F3_OR:      ctl = ALU_OR;
          F3_AND:     ctl = ALU_AND;
          F3_SLL: begin
            ctl   = ALU_SLL;
            b_sel = B_SHAMT;
            if (funct7 != F7_BASE) ctl_ill = 1'b1;
          end
          default: begin
            ctl   = alt ? ALU_SRA : ALU_SRL;
            b_sel = B_SHAMT;
            if ((funct7 != F7_BASE) && (funct7 != F7_ALT)) ctl_ill = 1'b1;
          end
        endcase
      end

      OPC_LUI: begin
        a_sel = A_ZERO;
        b_sel = B_IMM_U;
        wb_en = rd_nz;
      end

      OPC_AUIPC: begin
        a_sel = A_PC;
        b_sel = B_IMM_U;
        wb_en = rd_nz;
      end

      // Link value pc+4; the jump target is formed elsewhere.
      OPC_JAL, OPC_JALR: begin
        a_sel = A_PC;
        b_sel = B_FOUR;
        wb_en = rd_nz;
      end

      OPC_BRANCH: begin
        a_sel     = A_RS1;
        b_sel     = B_RS2;
        is_branch = 1'b1;
        unique case (funct3)
          F3_BEQ:  ctl = ALU_SEQ;
          F3_BNE:  ctl = ALU_SNE;
          F3_BLT:  ctl = ALU_SLT;
          F3_BGE:  ctl = ALU_SGE;
          F3_BLTU: ctl = ALU_SLTU;
          F3_BGEU: ctl = ALU_SGEU;
          default: ctl_ill = 1'b1;
        endcase
      end

      // Address generation only; the memory stage owns load writeback.
      OPC_LOAD: begin
        a_sel = A_RS1;
        b_sel = B_IMM_I;
      end

      OPC_STORE: begin
        a_sel = A_RS1;
        b_sel = B_IMM_S;
      end

      default: ctl_ill = 1'b1;
    endcase

    illegal = ctl_ill;
    if (ctl_ill) begin
      ctl       = ALU_ADD;
      a_sel     = A_ZERO;
      b_sel     = B_ZERO;
      wb_en     = 1'b0;
      is_branch = 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Registered decode/issue stage feeding the ALU operand and control inputs.
//   Ports:
//     clk, rst                      clock, synchronous active-high reset
//     in_valid/in_ready             upstream handshake
//     in_instr, in_pc               instruction word and its PC
//     in_rs1_data, in_rs2_data      register-file read data
//     flush                         kills held entry and same-cycle input
//     out_valid/out_ready           downstream (ALU/execute) handshake
//     out_a, out_b, out_ctl         ALU operands and control code
//     out_rd, out_wb_en             destination register (raw instr[11:7]), writeback
//     out_is_branch, out_illegal    branch-compare flag, decode trap flag
//     out_pc                        PC passed through
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. in_ready = ~out_valid | out_ready, so the single output register
//   refills in the same cycle it drains. Once out_valid is high the payload is
//   held stable until out_ready is seen (or flush/rst kills it). Precedence of
//   the next-state update is rst > flush > accept > drain.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [WORD_WIDTH-1:0]    in_pc,
  input  logic [WORD_WIDTH-1:0]    in_rs1_data,
  input  logic [WORD_WIDTH-1:0]    in_rs2_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_WIDTH-1:0]    out_a,
  output logic [WORD_WIDTH-1:0]    out_b,
  output logic [ALU_CTL_WIDTH-1:0] out_ctl,
  output logic [4:0]               out_rd,
  output logic                     out_wb_en,
  output logic                     out_is_branch,
  output logic                     out_illegal,
  output logic [WORD_WIDTH-1:0]    out_pc
);

  logic [ALU_CTL_WIDTH-1:0] dec_ctl;
  a_sel_e                   dec_a_sel;
  b_sel_e                   dec_b_sel;
  logic                     dec_wb_en;
  logic                     dec_is_branch;
  logic                     dec_illegal;

  alu_ctl_decode u_alu_ctl_decode (
    .opcode    (in_instr[6:0]),
    .funct3    (in_instr[14:12]),
    .funct7    (in_instr[31:25]),
    .rd        (in_instr[11:7]),
    .ctl       (dec_ctl),
    .a_sel     (dec_a_sel),
    .b_sel     (dec_b_sel),
    .wb_en     (dec_wb_en),
    .is_branch (dec_is_branch),
    .illegal   (dec_illegal)
  );

  // Immediates
  logic [WORD_WIDTH-1:0] imm_i;
  logic [WORD_WIDTH-1:0] imm_s;
  logic [WORD_WIDTH-1:0] imm_u;
  logic [WORD_WIDTH-1:0] imm_shamt;

  assign imm_i     = {{(WORD_WIDTH-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s     = {{(WORD_WIDTH-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_u     = {in_instr[31:12], 12'b0};
  assign imm_shamt = {{(WORD_WIDTH-SHAMT_WIDTH){1'b0}}, in_instr[20 +: SHAMT_WIDTH]};

  // Operand muxes
  logic [WORD_WIDTH-1:0] op_a;
  logic [WORD_WIDTH-1:0] op_b;

  always_comb begin
    op_a = '0;
    unique case (dec_a_sel)
      A_RS1:   op_a = in_rs1_data;
      A_PC:    op_a = in_pc;
      default: op_a = '0;
    endcase
  end

  always_comb begin
    op_b = '0;
    unique case (dec_b_sel)
      B_RS2:   op_b = in_rs2_data;
      B_IMM_I: op_b = imm_i;
      B_IMM_S: op_b = imm_s;
      B_IMM_U: op_b = imm_u;
      B_SHAMT: op_b = imm_shamt;
      B_FOUR:  op_b = WORD_WIDTH'(4);
      default: op_b = '0;
    endcase
  end

  // Output register
  logic   out_valid_d, out_valid_q;
  issue_t payload_d, payload_q;
  logic   accept;

  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready & ~flush;

  always_comb begin
    out_valid_d = out_valid_q;
    payload_d   = payload_q;
    if (flush) begin
      // Payload is left as is; only the valid bit matters once killed.
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d         = 1'b1;
      payload_d.a         = op_a;
      payload_d.b         = op_b;
      payload_d.ctl       = dec_ctl;
      payload_d.rd        = in_instr[11:7];
      payload_d.wb_en     = dec_wb_en;
      payload_d.is_branch = dec_is_branch;
      payload_d.illegal   = dec_illegal;
      payload_d.pc        = in_pc;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      payload_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      payload_q   <= payload_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_a         = payload_q.a;
  assign out_b         = payload_q.b;
  assign out_ctl       = payload_q.ctl;
  assign out_rd        = payload_q.rd;
  assign out_wb_en     = payload_q.wb_en;
  assign out_is_branch = payload_q.is_branch;
  assign out_illegal   = payload_q.illegal;
  assign out_pc        = payload_q.pc;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage
//   Directed RV32I words with hand-computed expected ALU inputs, driven
//   through the valid/ready handshake; a negedge monitor compares each
//   issued entry against an expected queue.
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;

  localparam int EW = 108;
  localparam int N  = 15;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                     in_valid;
  logic                     in_ready;
  logic [31:0]              in_instr;
  logic [WORD_WIDTH-1:0]    in_pc;
  logic [WORD_WIDTH-1:0]    in_rs1_data;
  logic [WORD_WIDTH-1:0]    in_rs2_data;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [WORD_WIDTH-1:0]    out_a;
  logic [WORD_WIDTH-1:0]    out_b;
  logic [ALU_CTL_WIDTH-1:0] out_ctl;
  logic [4:0]               out_rd;
  logic                     out_wb_en;
  logic                     out_is_branch;
  logic                     out_illegal;
  logic [WORD_WIDTH-1:0]    out_pc;

  alu_issue_stage dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .in_rs1_data   (in_rs1_data),
    .in_rs2_data   (in_rs2_data),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_a         (out_a),
    .out_b         (out_b),
    .out_ctl       (out_ctl),
    .out_rd        (out_rd),
    .out_wb_en     (out_wb_en),
    .out_is_branch (out_is_branch),
    .out_illegal   (out_illegal),
    .out_pc        (out_pc)
  );

  // scoreboard state
  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] cur_exp;
  logic          rand_rdy = 1'b0;

  logic [31:0]   t_instr[N];
  logic [31:0]   t_pc[N];
  logic [31:0]   t_rs1[N];
  logic [31:0]   t_rs2[N];
  logic [EW-1:0] t_exp[N];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic [31:0] a, input logic [31:0] b,
                                       input logic [3:0] ctl, input logic [4:0] rd,
                                       input logic wb, input logic br, input logic ill,
                                       input logic [31:0] pc);
    return {a, b, ctl, rd, wb, br, ill, pc};
  endfunction

  function automatic logic [EW-1:0] pack_out();
    return {out_a, out_b, out_ctl, out_rd, out_wb_en, out_is_branch, out_illegal, out_pc};
  endfunction

  task automatic set_entry(input int i, input logic [31:0] instr, input logic [31:0] pc,
                           input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [EW-1:0] e);
    t_instr[i] = instr;
    t_pc[i]    = pc;
    t_rs1[i]   = rs1;
    t_rs2[i]   = rs2;
    t_exp[i]   = e;
  endtask

  // driver
  task automatic drive(input int i);
    in_valid    = 1'b1;
    in_instr    = t_instr[i];
    in_pc       = t_pc[i];
    in_rs1_data = t_rs1[i];
    in_rs2_data = t_rs2[i];
    cur_exp     = t_exp[i];
  endtask

  task automatic send(input int i);
    logic took;
    drive(i);
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      took = in_ready && !flush;
      @(posedge clk);
      #1;
      if (took) begin
        in_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", 1, 0);
    in_valid = 1'b0;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      check("out_valid", out_valid, exp_q.size() != 0);
      check("in_ready", in_ready, (exp_q.size() == 0) || out_ready);
      if (out_valid && exp_q.size() != 0) begin
        check(out_ready ? "issue" : "hold", pack_out(), exp_q[0]);
        if (out_ready && !flush) void'(exp_q.pop_front());
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(cur_exp);
    end
  end

  // random out_ready
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    // stimulus table: instr, pc, rs1, rs2, expected {a,b,ctl,rd,wb,br,ill,pc}
    set_entry(0,  32'h002081B3, 32'h100, 32'd5, 32'd7,
              mk(32'd5, 32'd7, ALU_ADD, 5'd3, 1, 0, 0, 32'h100));            // ADD x3,x1,x2
    set_entry(1,  32'h40335293, 32'h104, 32'h80000000, 32'h1234,
              mk(32'h80000000, 32'd3, ALU_SRA, 5'd5, 1, 0, 0, 32'h104));     // SRAI x5,x6,3
    set_entry(2,  32'h123450B7, 32'h108, 32'hCAFEBABE, 32'h1,
              mk(32'd0, 32'h12345000, ALU_ADD, 5'd1, 1, 0, 0, 32'h108));     // LUI x1
    set_entry(3,  32'h0020C463, 32'h10C, 32'hFFFFFFFF, 32'd1,
              mk(32'hFFFFFFFF, 32'd1, ALU_SLT, 5'd8, 0, 1, 0, 32'h10C));     // BLT
    set_entry(4,  32'h40C58533, 32'h110, 32'd10, 32'd3,
              mk(32'd10, 32'd3, ALU_SUB, 5'd10, 1, 0, 0, 32'h110));          // SUB
    set_entry(5,  32'hFFF00013, 32'h114, 32'h55, 32'h66,
              mk(32'h55, 32'hFFFFFFFF, ALU_ADD, 5'd0, 0, 0, 0, 32'h114));    // ADDI x0 -> no wb
    set_entry(6,  32'hABCDE397, 32'h2000, 32'h11, 32'h22,
              mk(32'h2000, 32'hABCDE000, ALU_ADD, 5'd7, 1, 0, 0, 32'h2000)); // AUIPC
    set_entry(7,  32'h008000EF, 32'h3000, 32'h11, 32'h22,
              mk(32'h3000, 32'd4, ALU_ADD, 5'd1, 1, 0, 0, 32'h3000));        // JAL link
    set_entry(8,  32'hFE20AE23, 32'h118, 32'h1000, 32'hDEAD,
              mk(32'h1000, 32'hFFFFFFFC, ALU_ADD, 5'd28, 0, 0, 0, 32'h118)); // SW -4
    set_entry(9,  32'h0100A203, 32'h11C, 32'h2000, 32'h9,
              mk(32'h2000, 32'd16, ALU_ADD, 5'd4, 0, 0, 0, 32'h11C));        // LW 16
    set_entry(10, 32'h0041F063, 32'h120, 32'd3, 32'd4,
              mk(32'd3, 32'd4, ALU_SGEU, 5'd0, 0, 1, 0, 32'h120));           // BGEU
    set_entry(11, 32'hFFFFFFFF, 32'h124, 32'h77, 32'h88,
              mk(32'd0, 32'd0, ALU_ADD, 5'd31, 0, 0, 1, 32'h124));           // bad opcode
    set_entry(12, 32'h023100B3, 32'h128, 32'h77, 32'h88,
              mk(32'd0, 32'd0, ALU_ADD, 5'd1, 0, 0, 1, 32'h128));            // OP funct7=0000001
    set_entry(13, 32'h0020A063, 32'h12C, 32'h77, 32'h88,
              mk(32'd0, 32'd0, ALU_ADD, 5'd0, 0, 0, 1, 32'h12C));            // BRANCH funct3=010
    set_entry(14, 32'hFFF2A313, 32'h130, 32'h5, 32'h6,
              mk(32'h5, 32'hFFFFFFFF, ALU_SLT, 5'd6, 1, 0, 0, 32'h130));     // SLTI -1

    rst         = 1'b1;
    in_valid    = 1'b0;
    in_instr    = '0;
    in_pc       = '0;
    in_rs1_data = '0;
    in_rs2_data = '0;
    flush       = 1'b0;
    out_ready   = 1'b0;
    cur_exp     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_out", pack_out(), 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    // back-to-back stream with a consuming ALU
    out_ready = 1'b1;
    send(0);
    check("latency", out_valid, 1);
    for (int i = 1; i < N; i++) send(i);
    repeat (2) @(posedge clk);
    #1;

    // backpressure: held entry stays stable, new input waits
    out_ready = 1'b0;
    send(0);
    drive(1);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("bp_in_ready", in_ready, 0);
      check("bp_hold", pack_out(), t_exp[0]);
    end
    out_ready = 1'b1;
    send(1);
    @(posedge clk);
    #1;

    // flush kills held entry and drops the same-cycle input
    out_ready = 1'b0;
    send(2);
    drive(3);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", out_valid, 0);
    @(posedge clk);
    #1;
    check("flush_no_issue", out_valid, 0);

    // flush with an empty stage and a ready sink: input still dropped
    out_ready = 1'b1;
    drive(4);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_drop", out_valid, 0);

    // reset mid-stream
    out_ready = 1'b0;
    send(4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst2_valid", out_valid, 0);
    check("rst2_out", pack_out(), 0);
    rst = 1'b0;

    // random ready and random upstream gaps
    rand_rdy = 1'b1;
    for (int k = 0; k < 60; k++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) @(posedge clk);
      #1;
      send($urandom_range(0, N - 1));
    end
    rand_rdy  = 1'b0;
    #1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
    check("drain_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Registered decode/issue stage that drives the ALU's operand and control inputs (a, b, ctl), i.e. the producer end of the ALU interface.
- Accepts one RV32I instruction per cycle with its PC and register-file read data.
- Selects operands, maps opcode/funct3/funct7 to an ALU control code, and presents the result in an output register.
- Uses a valid/ready handshake with flush support; sits between the register-file read and the ALU in the core pipeline.

Parameters:
- None. Widths come from `WORD_WIDTH`, `ALU_CTL_WIDTH` and `SHAMT_WIDTH` in the shared defines.

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage can accept the instruction this cycle.
- in_instr  in  32  raw instruction word.
- in_pc  in  WORD_WIDTH  PC of in_instr.
- in_rs1_data  in  WORD_WIDTH  register-file value of rs1.
- in_rs2_data  in  WORD_WIDTH  register-file value of rs2.
- flush  in  1  kill the held entry and any same-cycle input.
- out_valid  out  1  issued entry valid.
- out_ready  in  1  ALU/execute consumes the entry.
- out_a  out  WORD_WIDTH  ALU operand a.
- out_b  out  WORD_WIDTH  ALU operand b.
- out_ctl  out  ALU_CTL_WIDTH  ALU control code.
- out_rd  out  5  destination register.
- out_wb_en  out  1  result is written back.
- out_is_branch  out  1  ALU result is a branch condition.
- out_illegal  out  1  opcode or funct not decodable.
- out_pc  out  WORD_WIDTH  PC passed through.

Behaviour:
- Reset, and flush when not in reset: out_valid=0. Reset also clears every out_* register to 0.
- Handshake: in_ready = ~out_valid | out_ready (combinational).
- Accept when in_valid & in_ready & ~flush; all out_* registers load next edge and out_valid=1. Latency is 1 cycle.
- Hold: while out_valid & ~out_ready, every out_* is stable.
- Drain: on out_ready with no accept, out_valid=0 next edge.
- Priority: rst > flush > accept. With flush=1 the same-cycle input is dropped and in_ready may still read 1.
- OP (0110011):
  - a=rs1, b=rs2.
  - funct3 000→ADD, or SUB if funct7[5]; 001→SLL; 010→SLT; 011→SLTU; 100→XOR; 101→SRL, or SRA if funct7[5]; 110→OR; 111→AND.
  - funct7 other than 0000000/0100000, or 0100000 with funct3∉{000,101} → illegal.
- OP-IMM (0010011):
  - a=rs1, b=sign-extended imm[11:0]. Same mapping without SUB; SLTI→SLT, SLTIU→SLTU.
  - Shifts: b = zero-extended shamt (SHAMT_WIDTH bits); funct7[5] selects SRA.
  - Shift funct7 ∉ {0000000, 0100000 for 101} → illegal.
- LUI: a=0, b={imm[31:12],12'b0}, ADD.
- AUIPC: a=pc, b={imm[31:12],12'b0}, ADD.
- JAL/JALR: a=pc, b=4, ADD (link value). Target computed elsewhere.
- BRANCH:
  - a=rs1, b=rs2, wb_en=0, is_branch=1.
  - funct3 000 SEQ, 001 SNE, 100 SLT, 101 SGE, 110 SLTU, 111 SGEU.
  - 010/011 → illegal.
- LOAD/STORE: address generation. a=rs1, b=sign-extended I/S immediate, ADD, wb_en=0.
- wb_en:
  - 1 for OP, OP-IMM, LUI, AUIPC, JAL, JALR, only if rd≠0.
  - 0 for LOAD here; memory stage owns the load writeback.
- Any other opcode or illegal case: illegal=1, ctl=ADD, a=b=0, wb_en=0, is_branch=0. The entry is still issued (out_valid=1) so the trap logic sees it.
- The out_ctl encoding always matches the ALU defines exactly; no new ctl values.

Decomposition:
- Shared defines header: RV32I opcode constants (OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE) and funct3 constants, alongside the existing ALU_* codes.
- One natural combinational sub-module, `alu_ctl_decode`: in_instr → ctl, operand-select, wb_en, is_branch, illegal.
- The top level holds operand muxing, immediate generation and the registered handshake.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 → next cycle out_valid=1, ctl=ALU_ADD, a=5, b=7, rd=3, wb_en=1.
- SRAI x5,x6,3 (0x40335293), rs1=0x80000000 → ctl=ALU_SRA, a=0x80000000, b=3, rd=5; LUI x1,0x12345 (0x123450B7) → a=0, b=0x12345000.
- BLT x1,x2,+8 (0x0020C463), rs1=0xFFFFFFFF, rs2=1 → ctl=ALU_SLT, is_branch=1, wb_en=0, illegal=0.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles, in_valid=1 → in_ready=0, all out_* unchanged; new instr accepted the cycle out_ready=1.
- flush=1 with out_valid=1 and in_valid=1 → out_valid=0 next cycle, input not issued. rst asserted mid-stream → out_valid=0, all outputs 0 next edge.
- Illegal word 0xFFFFFFFF and OP with funct7=0000001 → out_valid=1, illegal=1, wb_en=0, ctl=ALU_ADD.
